// File: rtl/rip_pseudo_core_launcher_pkg.sv
// Shared types and constants for the pseudo-core job launcher.
// Defines the launcher FSM states and the core busy-code encoding.
package rip_const;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        RELEASE = 2'd2,
        DRAIN   = 2'd3
    } launcher_state_t;

    localparam logic [1:0] CORE_SLEEP = 2'b00;
    localparam logic [1:0] CORE_INIT  = 2'b01;
    localparam logic [1:0] CORE_READ  = 2'b10;
    localparam logic [1:0] CORE_WRITE = 2'b11;

endpackage

// File: rtl/rip_pseudo_core_launcher_fifo.sv
// Small synchronous FIFO with wrap-bit pointers.
// The head entry is presented on o_data whenever the FIFO is not empty.
module rip_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/rip_pseudo_core_launcher.sv
// Queues aligned job addresses and presents them one at a time on mem_head,
// tracking the pseudo core's busy code to confirm start and completion.
module rip_pseudo_core_launcher
    import rip_const::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ALIGN_BITS = 10,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [ADDR_WIDTH-1:0] job_addr,
    output logic [ADDR_WIDTH-1:0] mem_head,
    input  logic [1:0]            core_busy,
    input  logic                  clr_err,
    output logic [CNT_WIDTH-1:0]  done_cnt,
    output logic [CNT_WIDTH-1:0]  reject_cnt,
    output logic                  timeout_err,
    output logic                  idle
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    launcher_state_t       r_state;
    launcher_state_t       w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_head;
    logic [ADDR_WIDTH-1:0] w_head_nxt;
    logic [TW-1:0]         r_timer;
    logic                  r_drain_seen;
    logic [CNT_WIDTH-1:0]  r_done_cnt;
    logic [CNT_WIDTH-1:0]  r_reject_cnt;
    logic                  r_timeout_err;

    logic                  w_addr_ok;
    logic                  w_push_hs;
    logic                  w_fifo_push;
    logic                  w_reject;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [ADDR_WIDTH-1:0] w_fifo_data;
    logic                  w_pop;
    logic                  w_done_inc;
    logic                  w_timeout_set;
    logic                  w_core_sleep;

    // All-ones is the core's "no job" marker, so it can never be a job.
    assign w_addr_ok    = (job_addr[ALIGN_BITS-1:0] == '0) && (job_addr != '1);
    assign w_push_hs    = job_valid && job_ready;
    assign w_fifo_push  = w_push_hs && w_addr_ok;
    assign w_reject     = w_push_hs && !w_addr_ok;
    assign w_core_sleep = (core_busy == CORE_SLEEP);

    rip_sync_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_fifo_push),
        .i_pop   (w_pop),
        .i_data  (job_addr),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // NOTE: state and datapath registers use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (!w_fifo_empty && w_core_sleep) w_state_nxt = ARM;
            ARM: begin
                if (core_busy[1])              w_state_nxt = RELEASE;
                else if (r_timer == TIMER_LAST) w_state_nxt = DRAIN;
            end
            RELEASE: if (w_core_sleep)                 w_state_nxt = IDLE;
            DRAIN:   if (w_core_sleep && r_drain_seen) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Leaving ARM by either exit drops mem_head so the core cannot restart the job.
    always_comb begin
        w_pop         = (r_state == IDLE)    && (w_state_nxt == ARM);
        w_done_inc    = (r_state == RELEASE) && (w_state_nxt == IDLE);
        w_timeout_set = (r_state == ARM)     && (w_state_nxt == DRAIN);
        w_head_nxt    = r_mem_head;
        if (w_pop)
            w_head_nxt = w_fifo_data;
        else if ((r_state == ARM) && (w_state_nxt != ARM))
            w_head_nxt = '1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_mem_head    <= '1;
            r_timer       <= '0;
            r_drain_seen  <= 1'b0;
            r_done_cnt    <= '0;
            r_reject_cnt  <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_mem_head <= w_head_nxt;

            if (w_pop)                   r_timer <= '0;
            else if (r_state == ARM)     r_timer <= r_timer + 1'b1;

            r_drain_seen <= (r_state == DRAIN) && w_core_sleep;

            if (w_done_inc && (r_done_cnt != '1))
                r_done_cnt <= r_done_cnt + CNT_WIDTH'(1);

            // A reject in the clearing cycle still counts.
            if (w_reject && clr_err)            r_reject_cnt <= CNT_WIDTH'(1);
            else if (clr_err)                   r_reject_cnt <= '0;
            else if (w_reject && (r_reject_cnt != '1))
                r_reject_cnt <= r_reject_cnt + CNT_WIDTH'(1);

            if (w_timeout_set)  r_timeout_err <= 1'b1;
            else if (clr_err)   r_timeout_err <= 1'b0;
        end
    end

    assign job_ready   = !w_fifo_full;
    assign mem_head    = r_mem_head;
    assign done_cnt    = r_done_cnt;
    assign reject_cnt  = r_reject_cnt;
    assign timeout_err = r_timeout_err;
    assign idle        = (r_state == IDLE) && w_fifo_empty;

endmodule

// File: tb/tb_rip_pseudo_core_launcher.sv
// Directed self-checking bench for rip_pseudo_core_launcher with a shortened
// timeout and narrow counters so saturation is reachable.
module tb_rip_pseudo_core_launcher;

    localparam int TOUT = 16;
    localparam int CW   = 3;
    localparam logic [31:0] NOJOB = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rstn;
    logic          job_valid;
    logic          job_ready;
    logic [31:0]   job_addr;
    logic [31:0]   mem_head;
    logic [1:0]    core_busy;
    logic          clr_err;
    logic [CW-1:0] done_cnt;
    logic [CW-1:0] reject_cnt;
    logic          timeout_err;
    logic          idle;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rip_pseudo_core_launcher #(
        .ADDR_WIDTH (32),
        .FIFO_DEPTH (4),
        .ALIGN_BITS (10),
        .TIMEOUT    (TOUT),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_addr    (job_addr),
        .mem_head    (mem_head),
        .core_busy   (core_busy),
        .clr_err     (clr_err),
        .done_cnt    (done_cnt),
        .reject_cnt  (reject_cnt),
        .timeout_err (timeout_err),
        .idle        (idle)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0; job_valid = 1'b0; job_addr = '0; core_busy = 2'b00; clr_err = 1'b0;
        step(2);
        rstn = 1'b1;
    endtask

    task automatic push(input logic [31:0] a);
        job_valid = 1'b1; job_addr = a;
        step();
        job_valid = 1'b0;
    endtask

    // Waits for a job on mem_head, then walks the core through read and sleep.
    task automatic run_job(input logic [31:0] exp);
        int n = 0;
        core_busy = 2'b00;
        while (mem_head === NOJOB && n < 20) begin
            step();
            n++;
        end
        check("job_addr_order", mem_head, exp);
        core_busy = 2'b10;
        step();
        check("job_release", mem_head, NOJOB);
        core_busy = 2'b00;
        step();
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_mem_head", mem_head, NOJOB);
        check("rst_done", 32'(done_cnt), 0);
        check("rst_reject", 32'(reject_cnt), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        check("rst_idle", 32'(idle), 1);
        check("rst_ready", 32'(job_ready), 1);

        // 1: single job, push->pop->mem_head, release on busy=10
        push(32'h0000_0400);
        check("t1_not_idle", 32'(idle), 0);
        step();
        check("t1_head", mem_head, 32'h400);
        step(2);
        check("t1_head_held", mem_head, 32'h400);
        core_busy = 2'b10;
        step();
        check("t1_release", mem_head, NOJOB);
        check("t1_done_pre", 32'(done_cnt), 0);
        core_busy = 2'b00;
        step();
        check("t1_done", 32'(done_cnt), 1);
        check("t1_idle", 32'(idle), 1);

        // 2: misaligned and all-ones pushes are rejected
        do_reset();
        check("t2_ready", 32'(job_ready), 1);
        push(32'h0000_0404);
        push(NOJOB);
        step(2);
        check("t2_reject", 32'(reject_cnt), 2);
        check("t2_head", mem_head, NOJOB);
        check("t2_done", 32'(done_cnt), 0);
        check("t2_idle", 32'(idle), 1);

        // 2b: clr_err with a same-cycle reject leaves count at 1; saturation at 7
        clr_err = 1'b1;
        push(32'h0000_0401);
        clr_err = 1'b0;
        check("t2_clr_reject_wins", 32'(reject_cnt), 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t2_clr", 32'(reject_cnt), 0);
        for (int i = 0; i < 9; i++) push(32'h0000_0001);
        check("t2_sat", 32'(reject_cnt), 7);

        // 3: fill the queue with the core stalled, then drain in FIFO order
        do_reset();
        core_busy = 2'b10;
        push(32'h0400);
        push(32'h0800);
        push(32'h0C00);
        check("t3_ready_3", 32'(job_ready), 1);
        push(32'h1000);
        check("t3_full", 32'(job_ready), 0);
        job_valid = 1'b1; job_addr = 32'h1400;
        core_busy = 2'b00;
        begin
            int n = 0;
            while (!job_ready && n < 10) begin
                step();
                n++;
            end
            check("t3_ready_again", 32'(job_ready), 1);
        end
        step();
        job_valid = 1'b0;
        run_job(32'h0400);
        run_job(32'h0800);
        run_job(32'h0C00);
        run_job(32'h1000);
        run_job(32'h1400);
        check("t3_done", 32'(done_cnt), 5);
        check("t3_idle", 32'(idle), 1);

        // 4: core never starts -> timeout exactly TOUT cycles into ARM
        do_reset();
        push(32'h2000);
        step();
        check("t4_arm", mem_head, 32'h2000);
        step(TOUT - 1);
        check("t4_no_tout_yet", 32'(timeout_err), 0);
        check("t4_head_still", mem_head, 32'h2000);
        step();
        check("t4_tout", 32'(timeout_err), 1);
        check("t4_head_drop", mem_head, NOJOB);
        step();
        check("t4_drain", 32'(idle), 0);
        step();
        check("t4_idle", 32'(idle), 1);
        check("t4_done", 32'(done_cnt), 0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t4_clr", 32'(timeout_err), 0);

        // 5: INIT phase holds mem_head; no restart after completion
        do_reset();
        push(32'h3000);
        step();
        core_busy = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_init_hold", mem_head, 32'h3000);
        end
        core_busy = 2'b10;
        step();
        check("t5_release", mem_head, NOJOB);
        core_busy = 2'b00;
        step();
        check("t5_done", 32'(done_cnt), 1);
        step(3);
        check("t5_no_restart", mem_head, NOJOB);
        check("t5_idle", 32'(idle), 1);

        // 6: reset during RELEASE with two jobs still queued
        do_reset();
        core_busy = 2'b10;
        push(32'h0400);
        push(32'h0800);
        push(32'h0C00);
        core_busy = 2'b00;
        step();
        check("t6_arm", mem_head, 32'h0400);
        core_busy = 2'b10;
        step();
        check("t6_release", mem_head, NOJOB);
        rstn = 1'b0;
        step();
        check("t6_rst_idle", 32'(idle), 1);
        check("t6_rst_ready", 32'(job_ready), 1);
        check("t6_rst_done", 32'(done_cnt), 0);
        check("t6_rst_head", mem_head, NOJOB);
        rstn = 1'b1;
        core_busy = 2'b00;
        step(2);
        check("t6_queue_empty", 32'(idle), 1);
        check("t6_no_pop", mem_head, NOJOB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
